rr_mux_arbiter: RTL and testbench
=================================

Name: rr_mux_arbiter

Overview:
Round-robin arbiter that shares the 4:1 single-bit multiplexer between four requesters. Each requester i drives data bit din[i] and raises req[i]. The arbiter grants one owner at a time and drives the mux selects (S1,S0) to that owner's index. The selected bit is presented on y, qualified by y_valid. A hold limit bounds each tenure, and a one-cycle dead gap separates consecutive grants.

Parameters:
MAX_HOLD, 8, maximum cycles a single grant is held before forced release (legal range 1..255).
HOLD_W, 8, width of the tenure counter; must satisfy 2**HOLD_W > MAX_HOLD.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-high
en  input  1  arbitration enable; low blocks new grants, does not cut an active grant
req  input  4  request per requester, level, held until done
din  input  4  data bit per requester (din[0]=A .. din[3]=D of the mux)
gnt  output  4  one-hot grant, registered
sel  output  2  mux select {S1,S0} = owner index, registered
y  output  1  muxed data bit = din[sel], combinational through the mux
y_valid  output  1  high while any gnt bit high (= |gnt)
busy  output  1  high in GRANT state
expired  output  1  one-cycle pulse when a grant is cut by the hold limit

Behaviour:
- Clocking: one clock (clk). Reset is synchronous and active-high (rst), sampled on the rising edge; it has priority over every other event.
- Reset values: state=IDLE, gnt=0000, sel=00, busy=0, expired=0, y_valid=0, hold_cnt=0, last=3. With last=3, requester 0 has top priority after reset.
- States: IDLE, GRANT, GAP.
- Arbitration (IDLE or GAP, en=1, req!=0):
  - Winner = first set req bit scanning last+1, last+2, last+3, last (mod 4).
  - At the next edge: gnt=onehot(winner), sel=winner, hold_cnt=0, state=GRANT.
- Grant latency: req sampled high in cycle N while IDLE -> gnt/sel valid in cycle N+1.
- IDLE or GAP with en=0 or req=0: next state IDLE; gnt stays 0000.
- GRANT:
  - hold_cnt increments each cycle.
  - Release when req[owner]==0 is sampled, or when hold_cnt==MAX_HOLD-1 (the owner then has had exactly MAX_HOLD cycles of gnt).
  - On release, at the next edge: gnt=0000, busy=0, last=owner, state=GAP.
  - expired=1 for that one cycle only if the release was forced and req[owner] was still 1.
- GAP: always exactly one cycle with gnt=0000 (guaranteed no-overlap cycle). It arbitrates like IDLE, so the new gnt appears in cycle N+2 after a release sampled in cycle N.
- Rotation: the just-released owner becomes lowest priority.
  - A lone requester that keeps req high is re-granted after every GAP.
  - Pattern: MAX_HOLD cycles on, 1 cycle off.
- sel holds the last granted index through GAP and IDLE; it is never changed while gnt=0000 except by a new grant. y is meaningful only when y_valid=1.
- en falling during GRANT: the current tenure completes normally. en is checked only in IDLE/GAP.
- Changes on non-owner req bits during GRANT: ignored until the next arbitration.
- MAX_HOLD=1: every grant lasts one cycle; a single persistent requester gives gnt 1,0,1,0...
- hold_cnt saturates logically: it never wraps, because release occurs at MAX_HOLD-1.
- rst mid-GRANT: at that edge gnt=0000, last=3, state=IDLE. No expired pulse.

Decomposition:
- Shared package rr_mux_pkg:
  - state encoding IDLE=2'd0, GRANT=2'd1, GAP=2'd2
  - N_REQ=4, SEL_W=2
  - function next_rr(last, req) returning the winner index
- One sub-module: the existing 4:1 multiplexer, instantiated with A..D=din[0..3], S0=sel[0], S1=sel[1], Y=y.
- Arbiter FSM, tenure counter and priority pointer live in the top level.

Test Plan:
1. rst=1 for 2 cycles with req=1111 -> gnt=0000, sel=00, busy=0, y_valid=0. Release rst, en=1 -> next cycle gnt=0001, sel=00.
2. req=0100, din=0100, en=1 -> one cycle later gnt=0100, sel=10, y=1, y_valid=1. Drop req[2] -> gnt=0000 next cycle (GAP), then IDLE.
3. req=1111 held, MAX_HOLD=8 -> grant order 0,1,2,3,0. Each tenure 8 cycles of gnt, 1 gap cycle, expired pulses once per tenure, never two gnt bits set.
4. req=0010 held alone, MAX_HOLD=1 -> gnt toggles 0010,0000,0010..., expired=1 on each 0000 cycle.
5. Grant 1 active, en driven 0 -> tenure runs to release. Afterwards gnt stays 0000 despite req=1111 until en=1; then winner is 2.
6. rst asserted in the 3rd cycle of grant 3 -> gnt=0000 next cycle. After release, req=1001 grants 0 first (pointer reset).

Source files
------------

// File: rtl/rr_mux_pkg.sv
// rtl/rr_mux_pkg.sv - shared types, sizes and round-robin pick for rr_mux_arbiter
package rr_mux_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  // Scan last+1, last+2, last+3, last (mod 4) and return the first requester found.
  // The index arithmetic wraps naturally in SEL_W bits.
  function automatic logic [SEL_W-1:0] next_rr(input logic [SEL_W-1:0] last,
                                               input logic [N_REQ-1:0] req);
    logic [SEL_W-1:0] idx;
    logic             found;
    next_rr = last;
    found   = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = last + SEL_W'(k);
      if (!found && req[idx]) begin
        next_rr = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_mux4.sv
// rtl/rr_mux_arbiter_mux4.sv - 4:1 single-bit multiplexer shared by the requesters
module rr_mux_arbiter_mux4 (
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic D,
  input  logic S0,
  input  logic S1,
  output logic Y
);

  // Select {S1,S0}: 0->A, 1->B, 2->C, 3->D.
  assign Y = S1 ? (S0 ? D : C) : (S0 ? B : A);

endmodule

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - round-robin arbiter driving the shared 4:1 mux selects
module rr_mux_arbiter
  import rr_mux_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] din,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             y,
  output logic             y_valid,
  output logic             busy,
  output logic             expired
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [SEL_W-1:0]  LAST_RST  = SEL_W'(N_REQ - 1);

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]  last_q, last_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              expired_q, expired_d;
  logic [SEL_W-1:0]  winner;
  logic              limit_hit;
  logic              owner_req;

  assign winner    = next_rr(last_q, req);
  assign limit_hit = (hold_cnt_q == HOLD_LAST);
  assign owner_req = req[sel_q];

  // State register; reset leaves requester 0 with top priority (last = 3).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      sel_q      <= '0;
      last_q     <= LAST_RST;
      hold_cnt_q <= '0;
      expired_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      expired_q  <= expired_d;
    end
  end

  // Next-state: arbitrate from IDLE/GAP, run the tenure in GRANT, always pass through one GAP cycle.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    expired_d  = 1'b0;
    unique case (state_q)
      GRANT: begin
        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        if (!owner_req || limit_hit) begin
          gnt_d      = '0;
          last_d     = sel_q;
          hold_cnt_d = '0;
          state_d    = GAP;
          expired_d  = owner_req;
        end
      end
      default: begin
        if (en && (req != '0)) begin
          gnt_d         = '0;
          gnt_d[winner] = 1'b1;
          sel_d         = winner;
          hold_cnt_d    = '0;
          state_d       = GRANT;
        end else begin
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
    endcase
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign y_valid = |gnt_q;
  assign busy    = (state_q == GRANT);
  assign expired = expired_q;

  rr_mux_arbiter_mux4 u_mux (
    .A  (din[0]),
    .B  (din[1]),
    .C  (din[2]),
    .D  (din[3]),
    .S0 (sel_q[0]),
    .S1 (sel_q[1]),
    .Y  (y)
  );

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - directed self-checking bench for rr_mux_arbiter
module tb_rr_mux_arbiter;

  logic       clk = 1'b0;
  logic       rst, en, rst1, en1;
  logic [3:0] req, din, req1;
  logic [3:0] gnt, gnt1;
  logic [1:0] sel, sel1;
  logic       y, y_valid, busy, expired;
  logic       y1, y_valid1, busy1, expired1;
  int         pass_cnt = 0;
  int         total_cnt = 0;

  always #5 clk = ~clk;

  rr_mux_arbiter #(.MAX_HOLD(8), .HOLD_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .din(din),
    .gnt(gnt), .sel(sel), .y(y), .y_valid(y_valid), .busy(busy), .expired(expired)
  );

  rr_mux_arbiter #(.MAX_HOLD(1), .HOLD_W(8)) dut1 (
    .clk(clk), .rst(rst1), .en(en1), .req(req1), .din(din),
    .gnt(gnt1), .sel(sel1), .y(y1), .y_valid(y_valid1), .busy(busy1), .expired(expired1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; req = 4'b1111; din = 4'b0000;
    tick(); tick();
    total_cnt++; if (gnt !== 4'b0000) $display("FAIL reset_gnt got %b want 0000", gnt); else pass_cnt++;
    total_cnt++; if (sel !== 2'b00) $display("FAIL reset_sel got %b want 00", sel); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (y_valid !== 1'b0) $display("FAIL reset_y_valid got %b want 0", y_valid); else pass_cnt++;
    total_cnt++; if (expired !== 1'b0) $display("FAIL reset_expired got %b want 0", expired); else pass_cnt++;
    rst = 1'b0;
    tick();
    total_cnt++; if (gnt !== 4'b0001) $display("FAIL reset_first_gnt got %b want 0001", gnt); else pass_cnt++;
    total_cnt++; if (sel !== 2'b00) $display("FAIL reset_first_sel got %b want 00", sel); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL reset_first_busy got %b want 1", busy); else pass_cnt++;
    req = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_single_grant();
    req = 4'b0100; din = 4'b0100;
    tick();
    total_cnt++; if (gnt !== 4'b0100) $display("FAIL single_gnt got %b want 0100", gnt); else pass_cnt++;
    total_cnt++; if (sel !== 2'b10) $display("FAIL single_sel got %b want 10", sel); else pass_cnt++;
    total_cnt++; if (y !== 1'b1) $display("FAIL single_y got %b want 1", y); else pass_cnt++;
    total_cnt++; if (y_valid !== 1'b1) $display("FAIL single_y_valid got %b want 1", y_valid); else pass_cnt++;
    din = 4'b1011;
    #1;
    total_cnt++; if (y !== 1'b0) $display("FAIL single_y_low got %b want 0", y); else pass_cnt++;
    din = 4'b0100; req = 4'b0000;
    tick();
    total_cnt++; if (gnt !== 4'b0000) $display("FAIL single_gap_gnt got %b want 0000", gnt); else pass_cnt++;
    total_cnt++; if (expired !== 1'b0) $display("FAIL single_gap_expired got %b want 0", expired); else pass_cnt++;
    total_cnt++; if (sel !== 2'b10) $display("FAIL single_gap_sel got %b want 10", sel); else pass_cnt++;
    tick();
    total_cnt++; if (gnt !== 4'b0000 || busy !== 1'b0) $display("FAIL single_idle got gnt=%b busy=%b want 0000/0", gnt, busy); else pass_cnt++;
    total_cnt++; if (sel !== 2'b10) $display("FAIL single_idle_sel got %b want 10", sel); else pass_cnt++;
  endtask

  task automatic test_rotation();
    logic [3:0] exp_g;
    int         on_cnt, exp_cnt, multi_cnt;
    rst = 1'b1; req = 4'b1111; en = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    for (int t = 0; t < 5; t++) begin
      exp_g = 4'b0001 << (t % 4);
      on_cnt = 0; exp_cnt = 0; multi_cnt = 0;
      for (int c = 0; c < 8; c++) begin
        if (gnt === exp_g && sel === 2'(t % 4)) on_cnt++;
        if (expired !== 1'b0) exp_cnt++;
        if ($countones(gnt) > 1) multi_cnt++;
        tick();
      end
      total_cnt++; if (on_cnt != 8) $display("FAIL rot_tenure%0d got %0d cycles want 8 of gnt %b", t, on_cnt, exp_g); else pass_cnt++;
      total_cnt++; if (exp_cnt != 0 || multi_cnt != 0) $display("FAIL rot_clean%0d got expired=%0d multi=%0d want 0/0", t, exp_cnt, multi_cnt); else pass_cnt++;
      total_cnt++; if (gnt !== 4'b0000) $display("FAIL rot_gap%0d got %b want 0000", t, gnt); else pass_cnt++;
      total_cnt++; if (expired !== 1'b1) $display("FAIL rot_expired%0d got %b want 1", t, expired); else pass_cnt++;
      if (t == 4) req = 4'b0000;
      tick();
    end
    total_cnt++; if (gnt !== 4'b0000 || expired !== 1'b0) $display("FAIL rot_idle got gnt=%b expired=%b want 0000/0", gnt, expired); else pass_cnt++;
  endtask

  task automatic test_max_hold_one();
    rst1 = 1'b0; en1 = 1'b1; req1 = 4'b0010;
    tick();
    for (int c = 0; c < 6; c++) begin
      if (c % 2 == 0) begin
        total_cnt++; if (gnt1 !== 4'b0010 || expired1 !== 1'b0) $display("FAIL mh1_on%0d got gnt=%b expired=%b want 0010/0", c, gnt1, expired1); else pass_cnt++;
      end else begin
        total_cnt++; if (gnt1 !== 4'b0000 || expired1 !== 1'b1) $display("FAIL mh1_off%0d got gnt=%b expired=%b want 0000/1", c, gnt1, expired1); else pass_cnt++;
      end
      tick();
    end
    req1 = 4'b0000;
  endtask

  task automatic test_enable_gate();
    int on_cnt;
    req = 4'b0010; en = 1'b1;
    tick();
    en = 1'b0; req = 4'b1111;
    on_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (gnt === 4'b0010) on_cnt++;
      tick();
    end
    total_cnt++; if (on_cnt != 8) $display("FAIL en_tenure got %0d cycles want 8", on_cnt); else pass_cnt++;
    total_cnt++; if (gnt !== 4'b0000 || expired !== 1'b1) $display("FAIL en_gap got gnt=%b expired=%b want 0000/1", gnt, expired); else pass_cnt++;
    on_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (gnt !== 4'b0000 || busy !== 1'b0) on_cnt++;
    end
    total_cnt++; if (on_cnt != 0) $display("FAIL en_blocked got %0d granted cycles want 0", on_cnt); else pass_cnt++;
    en = 1'b1;
    tick();
    total_cnt++; if (gnt !== 4'b0100 || sel !== 2'b10) $display("FAIL en_resume got gnt=%b sel=%b want 0100/10", gnt, sel); else pass_cnt++;
  endtask

  task automatic test_reset_mid_grant();
    req = 4'b0000;
    tick();
    req = 4'b1000;
    tick();
    total_cnt++; if (gnt !== 4'b1000) $display("FAIL rstmid_gnt3 got %b want 1000", gnt); else pass_cnt++;
    tick(); tick();
    rst = 1'b1;
    tick();
    total_cnt++; if (gnt !== 4'b0000 || busy !== 1'b0) $display("FAIL rstmid_cut got gnt=%b busy=%b want 0000/0", gnt, busy); else pass_cnt++;
    total_cnt++; if (expired !== 1'b0 || sel !== 2'b00) $display("FAIL rstmid_state got expired=%b sel=%b want 0/00", expired, sel); else pass_cnt++;
    rst = 1'b0; req = 4'b1001;
    tick();
    total_cnt++; if (gnt !== 4'b0001 || sel !== 2'b00) $display("FAIL rstmid_ptr got gnt=%b sel=%b want 0001/00", gnt, sel); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req = 4'b0000; din = 4'b0000;
    rst1 = 1'b1; en1 = 1'b0; req1 = 4'b0000;
    test_reset();
    test_single_grant();
    test_rotation();
    test_max_hold_one();
    test_enable_gate();
    test_reset_mid_grant();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
